// File: rtl/wb_writer.sv
// Write-back port driver: merges non-stalling ALU results with late multi-cycle
// results buffered in a small FIFO with WAW kill. Optional macro: WB_LATE_BYPASS_EN.
module wb_writer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_waddr,
    input  logic [DATA_W-1:0] alu_wdata,
    input  logic              late_valid,
    output logic              late_ready,
    input  logic [ADDR_W-1:0] late_waddr,
    input  logic [DATA_W-1:0] late_wdata,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic              pend1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic              pend2,
    output logic [ADDR_W:0]   fifo_cnt
);

    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] ent_addr_q  [DEPTH];
    logic [ADDR_W-1:0] ent_addr_d  [DEPTH];
    logic [DATA_W-1:0] ent_data_q  [DEPTH];
    logic [DATA_W-1:0] ent_data_d  [DEPTH];
    logic [DEPTH-1:0]  ent_valid_q, ent_valid_d;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic push, pop, kill, bypass, push_store;

    always_comb begin
        late_ready = rst & (cnt_q < (ADDR_W + 1)'(DEPTH));
        push       = late_valid & late_ready;
        kill       = alu_valid & (alu_waddr != '0);
        pop        = ~alu_valid & (cnt_q != '0);
`ifdef WB_LATE_BYPASS_EN
        bypass     = push & (cnt_q == '0) & ~alu_valid & (late_waddr != '0);
`else
        bypass     = 1'b0;
`endif
        push_store = push & (late_waddr != '0) & ~bypass;
    end

    // Queue update: kill, pop and push touch distinct slots except the
    // pushed slot, whose valid bit already folds in the same-cycle kill.
    always_comb begin
        ent_addr_d  = ent_addr_q;
        ent_data_d  = ent_data_q;
        ent_valid_d = ent_valid_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (kill && ent_addr_q[i] == alu_waddr)
                ent_valid_d[i] = 1'b0;
        end
        if (pop)
            ent_valid_d[head_q] = 1'b0;
        if (push_store) begin
            ent_addr_d[tail_q]  = late_waddr;
            ent_data_d[tail_q]  = late_wdata;
            ent_valid_d[tail_q] = ~(kill && late_waddr == alu_waddr);
        end
        head_d = head_q + PW'(pop);
        tail_d = tail_q + PW'(push_store);
        cnt_d  = cnt_q + {{ADDR_W{1'b0}}, push_store} - {{ADDR_W{1'b0}}, pop};
    end

    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (alu_valid) begin
            if (kill) begin
                we_d    = 1'b1;
                waddr_d = alu_waddr;
                wdata_d = alu_wdata;
            end
        end else if (pop) begin
            if (ent_valid_q[head_q]) begin
                we_d    = 1'b1;
                waddr_d = ent_addr_q[head_q];
                wdata_d = ent_data_q[head_q];
            end
        end else if (bypass) begin
            we_d    = 1'b1;
            waddr_d = late_waddr;
            wdata_d = late_wdata;
        end
    end

    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_valid_q[i] && ent_addr_q[i] == raddr1) pend1 = 1'b1;
            if (ent_valid_q[i] && ent_addr_q[i] == raddr2) pend2 = 1'b1;
        end
        if (push_store && late_waddr == raddr1) pend1 = 1'b1;
        if (push_store && late_waddr == raddr2) pend2 = 1'b1;
        pend1 = pend1 & (raddr1 != '0);
        pend2 = pend2 & (raddr2 != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_addr_q[i] <= '0;
                ent_data_q[i] <= '0;
            end
            ent_valid_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            ent_addr_q  <= ent_addr_d;
            ent_data_q  <= ent_data_d;
            ent_valid_q <= ent_valid_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign fifo_cnt = cnt_q;

endmodule
